// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin two-port arbiter and access sequencer for the
// single-port 32x16 data RAM. Each granted access runs IDLE -> ACCESS -> RESP
// and returns to the winner with a one-cycle ack in the following IDLE cycle.
module dram_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    state_t state;
    state_t state_next;

    // Arbitration results for the current IDLE cycle
    logic              elig0;
    logic              elig1;
    logic              grant_valid;
    logic              win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_oor;

    // Transaction context carried from the grant to the response
    logic              rr_last;
    logic              lat_id;
    logic              lat_we;
    logic              lat_oor;

    // Next values for every registered output and context register
    logic              rr_last_nxt;
    logic              lat_id_nxt;
    logic              lat_we_nxt;
    logic              lat_oor_nxt;
    logic              p0_ack_nxt;
    logic              p0_err_nxt;
    logic [DATA_W-1:0] p0_rdata_nxt;
    logic              p1_ack_nxt;
    logic              p1_err_nxt;
    logic [DATA_W-1:0] p1_rdata_nxt;
    logic              mem_write_en_nxt;
    logic              mem_read_en_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_data_in_nxt;
    logic              busy_nxt;

    // Pick a winner among eligible ports; a port being acked this cycle sits out.
    always_comb begin
        elig0       = p0_req && !p0_ack;
        elig1       = p1_req && !p1_ack;
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            win_id = ~rr_last;
        end else begin
            win_id = elig1;
        end
        win_we    = win_id ? p1_we    : p0_we;
        win_addr  = win_id ? p1_addr  : p0_addr;
        win_wdata = win_id ? p1_wdata : p0_wdata;
        win_oor   = ({1'b0, win_addr} >= DEPTH_LIMIT);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a grant starts a fixed ACCESS then RESP sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = grant_valid ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: compute next values of the registered outputs from the state.
    always_comb begin
        rr_last_nxt      = rr_last;
        lat_id_nxt       = lat_id;
        lat_we_nxt       = lat_we;
        lat_oor_nxt      = lat_oor;
        p0_ack_nxt       = 1'b0;
        p0_err_nxt       = p0_err;
        p0_rdata_nxt     = p0_rdata;
        p1_ack_nxt       = 1'b0;
        p1_err_nxt       = p1_err;
        p1_rdata_nxt     = p1_rdata;
        mem_write_en_nxt = 1'b0;
        mem_read_en_nxt  = 1'b0;
        mem_addr_nxt     = mem_addr;
        mem_data_in_nxt  = mem_data_in;
        busy_nxt         = (state_next != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    rr_last_nxt      = win_id;
                    lat_id_nxt       = win_id;
                    lat_we_nxt       = win_we;
                    lat_oor_nxt      = win_oor;
                    mem_addr_nxt     = win_addr;
                    mem_data_in_nxt  = win_wdata;
                    mem_write_en_nxt = win_we && !win_oor;
                    mem_read_en_nxt  = !win_we && !win_oor;
                end
            end
            RESP: begin
                if (lat_id) begin
                    p1_ack_nxt = 1'b1;
                    p1_err_nxt = lat_oor;
                    if (!lat_we) begin
                        p1_rdata_nxt = lat_oor ? '0 : mem_data_out;
                    end
                end else begin
                    p0_ack_nxt = 1'b1;
                    p0_err_nxt = lat_oor;
                    if (!lat_we) begin
                        p0_rdata_nxt = lat_oor ? '0 : mem_data_out;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Register outputs and transaction context; reset makes port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last      <= 1'b1;
            lat_id       <= 1'b0;
            lat_we       <= 1'b0;
            lat_oor      <= 1'b0;
            p0_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p0_rdata     <= '0;
            p1_ack       <= 1'b0;
            p1_err       <= 1'b0;
            p1_rdata     <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            busy         <= 1'b0;
        end else begin
            rr_last      <= rr_last_nxt;
            lat_id       <= lat_id_nxt;
            lat_we       <= lat_we_nxt;
            lat_oor      <= lat_oor_nxt;
            p0_ack       <= p0_ack_nxt;
            p0_err       <= p0_err_nxt;
            p0_rdata     <= p0_rdata_nxt;
            p1_ack       <= p1_ack_nxt;
            p1_err       <= p1_err_nxt;
            p1_rdata     <= p1_rdata_nxt;
            mem_write_en <= mem_write_en_nxt;
            mem_read_en  <= mem_read_en_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_data_in  <= mem_data_in_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed bench for dram_arbiter with a behavioural 32x16
// RAM (registered read address, combinational data out, preloaded words).
module tb_dram_arbiter;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_ack, p0_err, p1_ack, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_write_en, mem_read_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int wen_count = 0;
    int ren_count = 0;

    logic [DATA_W-1:0] ram [0:MEM_DEPTH-1];
    logic [4:0]        ram_raddr = '0;
    logic              ram_load  = 1'b1;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: preload once, then commit writes and capture read address on strobes.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < MEM_DEPTH; k++) ram[k] <= '0;
            ram[0] <= 16'hA5A5;
            ram[1] <= 16'h0050;
            ram[2] <= 16'h0032;
        end else begin
            if (mem_write_en) ram[mem_addr[4:0]] <= mem_data_in;
            if (mem_read_en)  ram_raddr <= mem_addr[4:0];
        end
    end

    assign mem_data_out = ram[ram_raddr];

    // Count RAM strobes so silent out-of-range accesses can be confirmed.
    always @(posedge clk) begin
        if (mem_write_en) wen_count <= wen_count + 1;
        if (mem_read_en)  ren_count <= ren_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one command on a port, wait (bounded) for its ack, then step past the ack cycle.
    task automatic run_single(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, output int lat,
                              output logic err, output logic [DATA_W-1:0] rd);
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (port == 0 && p0_ack) begin
                lat = i; err = p0_err; rd = p0_rdata; break;
            end
            if (port == 1 && p1_ack) begin
                lat = i; err = p1_err; rd = p1_rdata; break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
    endtask

    // Both ports read in the same cycle; report each port's ack latency and data.
    task automatic run_pair(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            output int lat0, output int lat1,
                            output logic [DATA_W-1:0] rd0, output logic [DATA_W-1:0] rd1);
        lat0 = -1; lat1 = -1; rd0 = 'x; rd1 = 'x;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = a0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = a1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (p0_ack && lat0 < 0) begin lat0 = i; rd0 = p0_rdata; p0_req = 1'b0; end
            if (p1_ack && lat1 < 0) begin lat1 = i; rd1 = p1_rdata; p1_req = 1'b0; end
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        rst = 1'b1;
        tick();
        ram_load = 1'b0;
        tick();
        n_cmp++; if ({p0_ack, p0_err, p1_ack, p1_err} !== 4'b0) begin n_bad++; $display("[TB] FAIL rst_ack_err: got %b expected 0000", {p0_ack, p0_err, p1_ack, p1_err}); end
        n_cmp++; if (p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin n_bad++; $display("[TB] FAIL rst_rdata: got %h/%h expected 0000/0000", p0_rdata, p1_rdata); end
        n_cmp++; if ({mem_write_en, mem_read_en, busy} !== 3'b0) begin n_bad++; $display("[TB] FAIL rst_strobes_busy: got %b expected 000", {mem_write_en, mem_read_en, busy}); end
        n_cmp++; if (mem_addr !== 9'h0 || mem_data_in !== 16'h0) begin n_bad++; $display("[TB] FAIL rst_mem_bus: got %h/%h expected 000/0000", mem_addr, mem_data_in); end
        rst = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_read();
        int lat; logic err; logic [DATA_W-1:0] rd;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'd5; p0_wdata = 16'h1234;
        tick();
        n_cmp++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_strobe_t1: got we=%b re=%b expected we=1 re=0", mem_write_en, mem_read_en); end
        n_cmp++; if (mem_addr !== 9'd5 || mem_data_in !== 16'h1234) begin n_bad++; $display("[TB] FAIL wr_bus_t1: got %h/%h expected 005/1234", mem_addr, mem_data_in); end
        n_cmp++; if (busy !== 1'b1 || p0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_busy_t1: got busy=%b ack=%b expected busy=1 ack=0", busy, p0_ack); end
        tick();
        n_cmp++; if (mem_write_en !== 1'b0 || p0_ack !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_t2: got we=%b ack=%b busy=%b expected 0/0/1", mem_write_en, p0_ack, busy); end
        tick();
        n_cmp++; if (p0_ack !== 1'b1 || p0_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_ack_t3: got ack=%b err=%b busy=%b expected 1/0/0", p0_ack, p0_err, busy); end
        p0_req = 1'b0;
        tick();
        n_cmp++; if (p0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_ack_t4: got %b expected 0", p0_ack); end
        run_single(0, 1'b0, 9'd5, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 16'h1234) begin n_bad++; $display("[TB] FAIL rd_addr5: got lat=%0d err=%b data=%h expected 3/0/1234", lat, err, rd); end
    endtask

    task automatic test_preinit();
        int lat; logic err; logic [DATA_W-1:0] rd;
        run_single(1, 1'b0, 9'd2, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 16'h0032) begin n_bad++; $display("[TB] FAIL p1_rd_addr2: got lat=%0d err=%b data=%h expected 3/0/0032", lat, err, rd); end
        run_single(1, 1'b0, 9'd1, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 16'h0050) begin n_bad++; $display("[TB] FAIL p1_rd_addr1: got lat=%0d err=%b data=%h expected 3/0/0050", lat, err, rd); end
        n_cmp++; if (p0_rdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL p0_rdata_undisturbed: got %h expected 1234", p0_rdata); end
    endtask

    task automatic test_tie();
        int lat0, lat1, lat; logic err; logic [DATA_W-1:0] rd0, rd1, rd;
        do_reset();
        run_pair(9'd1, 9'd1, lat0, lat1, rd0, rd1);
        n_cmp++; if (lat0 !== 3 || lat1 !== 6) begin n_bad++; $display("[TB] FAIL tie_after_reset: got lat0=%0d lat1=%0d expected 3/6", lat0, lat1); end
        n_cmp++; if (rd0 !== 16'h0050 || rd1 !== 16'h0050) begin n_bad++; $display("[TB] FAIL tie_data: got %h/%h expected 0050/0050", rd0, rd1); end
        run_single(0, 1'b0, 9'd2, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || rd !== 16'h0032) begin n_bad++; $display("[TB] FAIL tie_single_p0: got lat=%0d data=%h expected 3/0032", lat, rd); end
        run_pair(9'd1, 9'd2, lat0, lat1, rd0, rd1);
        n_cmp++; if (lat1 !== 3 || lat0 !== 6) begin n_bad++; $display("[TB] FAIL tie_p1_first: got lat0=%0d lat1=%0d expected 6/3", lat0, lat1); end
        n_cmp++; if (rd0 !== 16'h0050 || rd1 !== 16'h0032) begin n_bad++; $display("[TB] FAIL tie2_data: got %h/%h expected 0050/0032", rd0, rd1); end
    endtask

    task automatic test_out_of_range();
        int lat, wen0, ren0; logic err; logic [DATA_W-1:0] rd;
        wen0 = wen_count;
        run_single(1, 1'b1, 9'h040, 16'hFFFF, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b1) begin n_bad++; $display("[TB] FAIL oor_wr_ack: got lat=%0d err=%b expected 3/1", lat, err); end
        n_cmp++; if (wen_count !== wen0) begin n_bad++; $display("[TB] FAIL oor_wr_strobe: got %0d write strobes expected 0", wen_count - wen0); end
        n_cmp++; if (rd !== 16'h0032) begin n_bad++; $display("[TB] FAIL oor_wr_rdata_held: got %h expected 0032", rd); end
        ren0 = ren_count;
        run_single(1, 1'b0, 9'h040, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b1 || rd !== 16'h0000) begin n_bad++; $display("[TB] FAIL oor_rd: got lat=%0d err=%b data=%h expected 3/1/0000", lat, err, rd); end
        n_cmp++; if (ren_count !== ren0) begin n_bad++; $display("[TB] FAIL oor_rd_strobe: got %0d read strobes expected 0", ren_count - ren0); end
        run_single(1, 1'b0, 9'd0, 16'h0, lat, err, rd);
        n_cmp++; if (lat !== 3 || err !== 1'b0 || rd !== 16'hA5A5) begin n_bad++; $display("[TB] FAIL addr0_intact: got lat=%0d err=%b data=%h expected 3/0/a5a5", lat, err, rd); end
        n_cmp++; if (p0_rdata !== 16'h0050 || p0_err !== 1'b0) begin n_bad++; $display("[TB] FAIL p0_undisturbed: got %h err=%b expected 0050 err=0", p0_rdata, p0_err); end
    endtask

    task automatic test_reset_resp();
        int acks, lat0, lat1; logic [DATA_W-1:0] rd0, rd1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'd2;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || p0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_resp_state: got busy=%b ack=%b expected 0/0", busy, p0_ack); end
        rst = 1'b0;
        p0_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (p0_ack || p1_ack) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("[TB] FAIL rst_resp_no_ack: got %0d acks expected 0", acks); end
        run_pair(9'd1, 9'd2, lat0, lat1, rd0, rd1);
        n_cmp++; if (lat0 !== 3 || lat1 !== 6) begin n_bad++; $display("[TB] FAIL rst_resp_tie: got lat0=%0d lat1=%0d expected 3/6", lat0, lat1); end
        n_cmp++; if (rd0 !== 16'h0050 || rd1 !== 16'h0032) begin n_bad++; $display("[TB] FAIL rst_resp_data: got %h/%h expected 0050/0032", rd0, rd1); end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'd5;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (p0_ack) begin
                acks++;
                n_cmp++; if ((i % 4) != 3 || p0_rdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL stream_ack: got ack at cycle %0d data=%h expected cycle 3 mod 4 data=1234", i, p0_rdata); end
            end
        end
        p0_req = 1'b0;
        n_cmp++; if (acks !== 5) begin n_bad++; $display("[TB] FAIL stream_count: got %0d acks expected 5", acks); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_preinit();
        test_tie();
        test_out_of_range();
        test_reset_resp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port 32x16 data RAM (`dram`).
- Port 0 is the processor core; port 1 is a secondary master (loader or debug).
- The block arbitrates between them round-robin and drives the RAM's write_en/read_en/addr/Data_in strobes.
- It captures Data_out and returns it to the winner with a one-cycle ack pulse.
- It also rejects addresses outside the physical RAM depth.

Parameters:
- ADDR_W, 9, address width presented by requesters and to the RAM.
- DATA_W, 16, data word width.
- MEM_DEPTH, 32, number of physical RAM words; addr >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; hold with command stable until p0_ack.
- p0_we  in  1  1=write, 0=read.
- p0_addr  in  ADDR_W  word address.
- p0_wdata  in  DATA_W  write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  valid with p0_ack; 1 = address out of range.
- p0_rdata  out  DATA_W  read data, valid with p0_ack, held until the next port-0 read ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0.
- mem_write_en  out  1  to RAM write_en.
- mem_read_en  out  1  to RAM read_en.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_data_in  out  DATA_W  to RAM Data_in.
- mem_data_out  in  DATA_W  from RAM Data_out; combinational from the RAM's registered read address.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. Reset values: acks, errs, rdata, mem strobes, mem_addr, mem_data_in, busy = 0; state = IDLE; rr_last = 1, so port 0 wins the first tie.
- State IDLE, at posedge:
  - Sample eligible requests. A port whose ack is high this cycle is masked.
  - None eligible: stay IDLE.
  - One eligible: that port wins. Both eligible: the port != rr_last wins.
  - Latch winner id, we, addr, wdata; set rr_last = winner; go to ACCESS.
- State ACCESS (one cycle):
  - mem_addr = latched addr.
  - In range: mem_write_en = we, mem_read_en = !we, mem_data_in = wdata.
  - Out of range: both strobes 0.
  - RAM commits write / read-address update at the end of this cycle. Go to RESP.
- State RESP (one cycle):
  - Strobes 0. mem_addr and mem_data_in hold their values (don't care).
  - At posedge, for the winner: ack <= 1; err <= out_of_range.
  - If read: rdata <= in-range ? mem_data_out : 0. If write: rdata is unchanged.
  - Go to IDLE.
- Ack is high for exactly one cycle, in the first IDLE cycle after RESP. The non-winner's ack, err and rdata are never disturbed.
- Latency: request sampled at the end of cycle T → ack high in cycle T+3.
- Throughput: one access per 4 cycles per port. Alternating ports: the other port can be sampled in the winner's ack cycle, giving a back-to-back grant.
- Requesters must hold their command stable from req assertion until the ack cycle. Changes after the IDLE sample are ignored.
- Range check: out_of_range = (addr >= MEM_DEPTH), evaluated on the latched address.
- Reset mid-operation:
  - rst returns to IDLE at the next posedge.
  - A pending transaction is dropped with no ack.
  - If rst is asserted during ACCESS, that cycle's write still commits in the RAM (strobe already driven). The requester must reissue.
- rst does not clear RAM contents.
- Requests are never lost while rst = 0: a losing port keeps req high and wins the next arbitration.

Test Plan:
- Directed write/read on port 0:
  - Write 0x1234 to addr 5 (req at end of T) → mem_write_en high in T+1 only; p0_ack in T+3 with p0_err = 0.
  - Then read addr 5 → p0_rdata = 0x1234 with p0_ack.
- Preinitialized words via port 1: read addr 2 → p1_rdata = 0x0032; read addr 1 → 0x0050.
- Tie-breaking after reset:
  - Both ports request reads of addr 1 at T → p0_ack in T+3, p1_ack in T+6.
  - Next simultaneous pair → port 1 served first.
- Out-of-range on port 1:
  - Write addr 0x040 data 0xFFFF → mem_write_en stays 0; p1_ack with p1_err = 1.
  - Read addr 0x040 → p1_rdata = 0, p1_err = 1.
  - Addr 0 contents unchanged.
- Reset during RESP: assert rst → no ack ever issued; busy = 0 next cycle; next request proceeds normally, with port 0 winning a tie.
- Port 0 holds req high continuously (reads) → p0_ack every 4th cycle; never two acks within 3 cycles.
